fifo_rr_drain_arbiter: RTL and testbench

- Drains NUM_CH source fifo instances (1-cycle registered read: rd_en at cycle t gives valid/dout at t+1) into one shared output stream.
- Arbitrates round-robin with bounded bursts, tags each in-flight read, and lands data in a 2-entry output skid buffer.
- Sits between the per-channel fifo banks and the single downstream consumer, e.g. a shared processing unit.

---
 rtl/fifo_rr_drain_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_fifo_rr_drain_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain_arbiter.sv
// fifo_rr_drain_arbiter
// Drains NUM_CH registered-read source fifos into one output stream.
// Channels are served round-robin with bursts of up to MAX_BURST reads.
// Each read is tagged with its channel, and the returned word lands in a
// 2-entry skid buffer. A credit check keeps the buffer from overflowing.
// Optional build macro FIFO_ARB_TAG_EN adds out_chan, the source channel
// of out_data, which is stored in the skid buffer next to the data.
module fifo_rr_drain_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int LOG2_NUM_CH = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_BURST   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_empty,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_dout,
  output logic [NUM_CH-1:0]            ch_rd_en,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef FIFO_ARB_TAG_EN
  output logic [LOG2_NUM_CH-1:0]       out_chan,
`endif
  output logic                         busy,
  output logic                         err
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef logic [LOG2_NUM_CH-1:0] ch_idx_t;
  typedef enum logic {ARB, BURST} state_t;

  // Arbiter state
  state_t           state;
  ch_idx_t          rr_ptr;
  ch_idx_t          grant;
  logic [CNT_W-1:0] burst_cnt;

  // Read tracking and skid buffer
  logic                  inflight;
  ch_idx_t               tag;
  logic                  head;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] data_mem [2];
`ifdef FIFO_ARB_TAG_EN
  ch_idx_t               chan_mem [2];
`endif

  // Combinational helpers
  logic                  found;
  ch_idx_t               found_idx;
  ch_idx_t               cand_idx;
  int                    cand;
  logic                  pop;
  logic [2:0]            occ;
  logic                  issue_ok;
  logic                  issue;
  ch_idx_t               issue_idx;
  logic [DATA_WIDTH-1:0] ch_word [NUM_CH];
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_CH-1:0]     exp_valid;
  logic                  push;
  logic                  err_set;
  logic                  tail;

  function automatic ch_idx_t next_idx(input ch_idx_t i);
    return (int'(i) == NUM_CH - 1) ? '0 : i + 1'b1;
  endfunction

  // Unpack the flat per-channel data bus
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_word[g] = ch_dout[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign out_valid = (buf_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign busy      = inflight || out_valid;
  // Words already committed (buffered or returning) minus the one leaving now
  assign occ       = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue_ok  = (occ < 3'd2);
  assign out_data  = data_mem[head];
`ifdef FIFO_ARB_TAG_EN
  assign out_chan  = chan_mem[head];
`endif

  // Find the first non-empty channel at or after the round-robin pointer
  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = ch_idx_t'(cand);
      if (!found && !ch_empty[cand_idx]) begin
        found     = 1'b1;
        found_idx = cand_idx;
      end
    end
  end

  // Issue decision and one-hot read enable
  always_comb begin
    issue     = 1'b0;
    issue_idx = grant;
    ch_rd_en  = '0;
    case (state)
      ARB: begin
        if (found && issue_ok) begin
          issue     = 1'b1;
          issue_idx = found_idx;
        end
      end
      BURST: begin
        if (!ch_empty[grant] && (burst_cnt < MAX_CNT) && issue_ok) begin
          issue = 1'b1;
        end
      end
      default: issue = 1'b0;
    endcase
    // Reset must silence the fifos in the very cycle it is applied
    if (!rst_n) issue = 1'b0;
    if (issue) ch_rd_en[issue_idx] = 1'b1;
  end

  // Returning-word routing and protocol check
  always_comb begin
    sel_data  = ch_word[tag];
    exp_valid = '0;
    if (inflight) exp_valid[tag] = 1'b1;
  end

  assign push    = inflight && ch_valid[tag];
  assign err_set = |(ch_valid & ~exp_valid);
  // With 0 or 1 entries the free slot sits at head + buf_cnt
  assign tail    = head ^ buf_cnt[0];

  // Round-robin / burst arbiter FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB;
      rr_ptr    <= '0;
      grant     <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (issue) begin
            grant     <= issue_idx;
            burst_cnt <= CNT_W'(1);
            if (MAX_BURST > 1) state  <= BURST;
            else               rr_ptr <= next_idx(issue_idx);
          end
        end
        BURST: begin
          if (ch_empty[grant] || (burst_cnt == MAX_CNT)) begin
            rr_ptr <= next_idx(grant);
            state  <= ARB;
          end else if (issue) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // In-flight tag, skid buffer and sticky error
  // NOTE: the two buffer entries are reset too, so out_data reads 0 after
  // reset instead of leftover contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      tag         <= '0;
      head        <= 1'b0;
      buf_cnt     <= 2'd0;
      data_mem[0] <= '0;
      data_mem[1] <= '0;
`ifdef FIFO_ARB_TAG_EN
      chan_mem[0] <= '0;
      chan_mem[1] <= '0;
`endif
      err         <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) tag <= issue_idx;
      if (push) begin
        data_mem[tail] <= sel_data;
`ifdef FIFO_ARB_TAG_EN
        chan_mem[tail] <= tag;
`endif
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// tb_fifo_rr_drain_arbiter
// Source fifos are bench queues with a 1-cycle registered read. A queue
// based reference model predicts every output each cycle; directed
// scenarios add literal expectations on the logged outputs.
module tb_fifo_rr_drain_arbiter;
  localparam int NUM_CH = 4;
  localparam int LOG2   = 2;
  localparam int DW     = 8;
  localparam int MAXB   = 4;
  localparam int LOGN   = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] ch_empty = '1;
  logic [NUM_CH-1:0] ch_valid = '0;
  logic [NUM_CH*DW-1:0] ch_dout = '0;
  logic [NUM_CH-1:0] ch_rd_en;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err;
`ifdef FIFO_ARB_TAG_EN
  logic [LOG2-1:0]   out_chan;
`endif

  fifo_rr_drain_arbiter #(
    .NUM_CH(NUM_CH), .LOG2_NUM_CH(LOG2), .DATA_WIDTH(DW), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_empty(ch_empty), .ch_valid(ch_valid), .ch_dout(ch_dout),
    .ch_rd_en(ch_rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef FIFO_ARB_TAG_EN
    .out_chan(out_chan),
`endif
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- source fifo environment ----------------
  logic [DW-1:0]     src    [NUM_CH][$];
  logic [DW-1:0]     shadow [NUM_CH][$];
  logic [NUM_CH-1:0] rd_s = '0;
  logic              inject_err = 1'b0;

  always @(negedge clk) rd_s = ch_rd_en;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_s[i] && src[i].size() > 0) begin
        ch_dout[i*DW +: DW] = src[i].pop_front();
        ch_valid[i] = 1'b1;
      end else begin
        ch_valid[i] = 1'b0;
      end
    end
    if (inject_err) ch_valid[3] = 1'b1;
    for (int i = 0; i < NUM_CH; i++) ch_empty[i] = (src[i].size() == 0);
  end

  task automatic load(input int c, input logic [DW-1:0] w);
    src[c].push_back(w);
    shadow[c].push_back(w);
  endtask

  // ---------------- reference model and per-cycle compare ----------------
  typedef struct packed {
    logic [LOG2-1:0] ch;
    logic [DW-1:0]   d;
  } word_t;

  word_t outq[$];
  word_t pend;
  bit    pend_v  = 0;
  bit    m_burst = 0;
  bit    m_err   = 0;
  int    m_rr    = 0;
  int    m_grant = 0;
  int    m_cnt   = 0;

  logic [NUM_CH-1:0] log_rd   [LOGN];
  logic              log_ov   [LOGN];
  logic [DW-1:0]     log_od   [LOGN];
  logic              log_busy [LOGN];
  logic              log_err  [LOGN];
  logic [DW-1:0]     got[$];
  int                pop_cyc[$];

  always @(negedge clk) begin
    bit pop_m, credit, issue, found, leave;
    int ich, c;
    logic [NUM_CH-1:0] exp_rd;

    pop_m  = (outq.size() != 0) && out_ready;
    credit = (outq.size() + int'(pend_v) - int'(pop_m)) < 2;
    issue  = 0;
    leave  = 0;
    found  = 0;
    ich    = 0;
    if (!m_burst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (!found && !ch_empty[c]) begin
          found = 1;
          ich   = c;
        end
      end
      issue = found && credit;
    end else begin
      leave = ch_empty[m_grant] || (m_cnt == MAXB);
      issue = !leave && credit;
      ich   = m_grant;
    end
    if (!rst_n) issue = 0;
    exp_rd = '0;
    if (issue) exp_rd[ich] = 1'b1;

    check("rd_en", 32'(ch_rd_en), 32'(exp_rd));
    check("rd_en_to_empty", 32'(ch_rd_en & ch_empty), 32'd0);
    check("rd_en_onehot0", 32'($onehot0(ch_rd_en)), 32'd1);
    check("out_valid", 32'(out_valid), 32'(outq.size() != 0));
    if (outq.size() != 0) begin
      check("out_data", 32'(out_data), 32'(outq[0].d));
`ifdef FIFO_ARB_TAG_EN
      check("out_chan", 32'(out_chan), 32'(outq[0].ch));
`endif
    end
    check("busy", 32'(busy), 32'(pend_v || outq.size() != 0));
    check("err", 32'(err), 32'(m_err));

    if (cyc < LOGN) begin
      log_rd[cyc]   = ch_rd_en;
      log_ov[cyc]   = out_valid;
      log_od[cyc]   = out_data;
      log_busy[cyc] = busy;
      log_err[cyc]  = err;
    end
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      pop_cyc.push_back(cyc);
    end

    // advance the model across the coming edge
    if (!rst_n) begin
      outq.delete();
      pend_v  = 0;
      m_burst = 0;
      m_err   = 0;
      m_rr    = 0;
      m_grant = 0;
      m_cnt   = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (ch_valid[i] && !(pend_v && int'(pend.ch) == i)) m_err = 1;
      if (pop_m) void'(outq.pop_front());
      if (pend_v && ch_valid[pend.ch]) outq.push_back(pend);
      pend_v = issue;
      if (issue) begin
        pend.ch = LOG2'(ich);
        pend.d  = (shadow[ich].size() > 0) ? shadow[ich].pop_front() : 'x;
      end
      if (!m_burst) begin
        if (issue) begin
          m_grant = ich;
          m_cnt   = 1;
          if (MAXB > 1) m_burst = 1;
          else          m_rr = (ich + 1) % NUM_CH;
        end
      end else if (leave) begin
        m_rr    = (m_grant + 1) % NUM_CH;
        m_burst = 0;
      end else if (issue) begin
        m_cnt++;
      end
    end
    cyc++;
  end

  // ---------------- helpers on the logged outputs ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int find_rd(input int from);
    for (int i = from; i < cyc && i < LOGN; i++)
      if (log_rd[i] != '0) return i;
    return -1;
  endfunction

  function automatic int count_rd(input int from, input int upto);
    int n = 0;
    for (int i = from; i < upto && i < LOGN; i++)
      if (log_rd[i] != '0) n++;
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int t, start, s0, rel, x, k, n, first, last;
    int rd_cyc[$];
    logic [NUM_CH-1:0] rd_val[$];
    logic [DW-1:0] exp_w[$];

    rst_n      = 1'b0;
    out_ready  = 1'b1;
    inject_err = 1'b0;
    tick(); tick(); tick();
    // reset state
    check("rst_out_valid", 32'(log_ov[cyc-1]), 32'd0);
    check("rst_out_data", 32'(log_od[cyc-1]), 32'd0);
    check("rst_busy", 32'(log_busy[cyc-1]), 32'd0);
    check("rst_err", 32'(log_err[cyc-1]), 32'd0);
    check("rst_rd_en", 32'(log_rd[cyc-1]), 32'd0);
    rst_n = 1'b1;

    // single word from ch2
    start = cyc;
    load(2, 8'h5A);
    repeat (8) tick();
    t = find_rd(start);
    check("s1_rd_seen", 32'(t >= 0), 32'd1);
    if (t < 0) t = 0;
    check("s1_rd_en", 32'(log_rd[t]), 32'b0100);
    check("s1_not_valid_t1", 32'(log_ov[t+1]), 32'd0);
    check("s1_valid_t2", 32'(log_ov[t+2]), 32'd1);
    check("s1_data_t2", 32'(log_od[t+2]), 32'h5A);
    check("s1_busy_t3", 32'(log_busy[t+3]), 32'd0);
    check("s1_err", 32'(err), 32'd0);

    // round robin with bursts: 4 channels x 6 words
    do_reset();
    got.delete();
    start = cyc;
    for (int c = 0; c < NUM_CH; c++)
      for (int w = 0; w < 6; w++) load(c, DW'(c * 16 + w));
    repeat (60) tick();
    exp_w.delete();
    for (int c = 0; c < NUM_CH; c++)
      for (int w = 0; w < 4; w++) exp_w.push_back(DW'(c * 16 + w));
    for (int c = 0; c < NUM_CH; c++)
      for (int w = 4; w < 6; w++) exp_w.push_back(DW'(c * 16 + w));
    check("s2_word_count", 32'(got.size()), 32'd24);
    for (int i = 0; i < 24 && i < got.size(); i++)
      check($sformatf("s2_word_%0d", i), 32'(got[i]), 32'(exp_w[i]));
    check("s2_rd_pulses", 32'(count_rd(start, cyc)), 32'd24);
    first = find_rd(start);
    last  = first;
    for (int i = start; i < cyc; i++) if (log_rd[i] != '0) last = i;
    // 24 reads plus one idle exit cycle between each of the 8 bursts
    check("s2_rd_span", 32'(last - first + 1), 32'd31);

    // backpressure: ch0 8 words, consumer stalled 10 cycles
    do_reset();
    got.delete();
    pop_cyc.delete();
    out_ready = 1'b0;
    for (int w = 0; w < 8; w++) load(0, DW'(8'hA0 + w));
    s0 = cyc;
    repeat (10) tick();
    rel = cyc;
    out_ready = 1'b1;
    repeat (20) tick();
    check("s3_stall_rd_pulses", 32'(count_rd(s0, rel)), 32'd2);
    check("s3_stall_valid", 32'(log_ov[rel-1]), 32'd1);
    check("s3_stall_head_mid", 32'(log_od[s0+4]), 32'hA0);
    check("s3_stall_head_end", 32'(log_od[rel-1]), 32'hA0);
    check("s3_pop_count", 32'(got.size()), 32'd8);
    // pops run every cycle except one bubble caused by the rotation idle cycle
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      check($sformatf("s3_word_%0d", i), 32'(got[i]), 32'(8'hA0 + i));
      check($sformatf("s3_pop_cycle_%0d", i), 32'(pop_cyc[i] - rel), 32'(i + (i >= 4 ? 1 : 0)));
    end

    // empty mid-burst: ch1 2 words, ch3 3 words
    do_reset();
    start = cyc;
    load(1, 8'h11); load(1, 8'h12);
    load(3, 8'h31); load(3, 8'h32); load(3, 8'h33);
    repeat (20) tick();
    rd_cyc.delete();
    rd_val.delete();
    for (int i = start; i < cyc; i++)
      if (log_rd[i] != '0) begin
        rd_cyc.push_back(i);
        rd_val.push_back(log_rd[i]);
      end
    check("s4_rd_count", 32'(rd_cyc.size()), 32'd5);
    if (rd_cyc.size() == 5) begin
      check("s4_rd0", 32'(rd_val[0]), 32'b0010);
      check("s4_rd1", 32'(rd_val[1]), 32'b0010);
      check("s4_rd2", 32'(rd_val[2]), 32'b1000);
      check("s4_rd3", 32'(rd_val[3]), 32'b1000);
      check("s4_rd4", 32'(rd_val[4]), 32'b1000);
      check("s4_exit_gap", 32'(rd_cyc[2] - rd_cyc[0]), 32'd3);
      check("s4_ch3_run", 32'(rd_cyc[4] - rd_cyc[2]), 32'd2);
    end

    // reset mid-stream, then restart from ch0
    do_reset();
    start = cyc;
    for (int w = 0; w < 6; w++) load(2, DW'(8'hC0 + w));
    n = 0;
    while (n < 20 && count_rd(start, cyc) < 3) begin
      tick();
      n++;
    end
    check("s5_reads_before_reset", 32'(count_rd(start, cyc)), 32'd3);
    rst_n = 1'b0;
    load(0, 8'hD0); load(0, 8'hD1);
    x = cyc;
    tick(); tick();
    rst_n = 1'b1;
    check("s5_busy_at_reset", 32'(log_busy[x]), 32'd1);
    check("s5_rd_during_reset", 32'(log_rd[x]), 32'd0);
    check("s5_valid_after", 32'(log_ov[x+1]), 32'd0);
    check("s5_rd_after", 32'(log_rd[x+1]), 32'd0);
    check("s5_busy_after", 32'(log_busy[x+1]), 32'd0);
    start = cyc;
    repeat (30) tick();
    t = find_rd(start);
    check("s5_restart_seen", 32'(t >= 0), 32'd1);
    if (t < 0) t = 0;
    check("s5_restart_ch0", 32'(log_rd[t]), 32'b0001);
    check("s5_drained", 32'(busy), 32'd0);

    // protocol error: spurious ch_valid[3]
    k = cyc;
    inject_err = 1'b1;
    tick();
    inject_err = 1'b0;
    repeat (6) tick();
    check("s6_err_before", 32'(log_err[k+1]), 32'd0);
    check("s6_err_set", 32'(log_err[k+2]), 32'd1);
    check("s6_err_sticky", 32'(log_err[k+6]), 32'd1);
    do_reset();
    check("s6_err_cleared", 32'(log_err[cyc-1]), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
